keyed_dup_seq_ctrl: RTL and testbench

- Parametrised, key-locked multi-step accumulate sequencer for the obfuscated-FSM benchmark set.
- Every step state k has a real copy Rk and a decoy copy Dk; key bit k selects which copy is entered.
- Unlike the fixed single-duplicate controllers, it generalises the duplication to KEY_W steps, has a selectable corruption mode, and has a start/done/ack handshake.
- Sits between a stimulus source and a result consumer in locking-evaluation testbenches.

---
 rtl/keyed_fsm_pkg.sv | 36 +++
 rtl/keyed_step_acc.sv | 44 ++++
 rtl/keyed_dup_seq_ctrl.sv | 115 +++++++++++
 tb/tb_keyed_dup_seq_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keyed_fsm_pkg.sv
// Shared types and helpers for key-locked duplicated-state sequencers.
// Provides the phase enum, the packed state word (phase, step index, decoy
// flag), the accumulator operation enum and the key routing function.
package keyed_fsm_pkg;

  // Fixed index field width; supports up to 256 step states.
  localparam int unsigned IDX_W = 8;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_STEP = 2'd1,
    PH_DONE = 2'd2
  } phase_e;

  typedef struct packed {
    phase_e           phase;
    logic [IDX_W-1:0] idx;
    logic             decoy;
  } state_t;

  typedef enum logic [1:0] {
    ACC_HOLD  = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_ADD   = 2'd2,
    ACC_CLEAR = 2'd3
  } acc_op_e;

  localparam state_t ST_IDLE = '{phase: PH_IDLE, idx: '0, decoy: 1'b0};
  localparam state_t ST_DONE = '{phase: PH_DONE, idx: '0, decoy: 1'b0};

  // A key bit that disagrees with the correct value routes into the decoy copy.
  function automatic logic key_route(input logic key_bit, input logic val_bit);
    return key_bit != val_bit;
  endfunction

endpackage

// File: rtl/keyed_step_acc.sv
// Accumulator register with load/add/clear operations.
// Ports: clk, rst (async active-high), i_op (operation), i_x (operand,
// zero-extended), i_decoy (current step is a decoy copy), o_acc (register).
module keyed_step_acc
  import keyed_fsm_pkg::*;
#(
  parameter int unsigned IN_W    = 4,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned CORRUPT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  acc_op_e          i_op,
  input  logic [IN_W-1:0]  i_x,
  input  logic             i_decoy,
  output logic [OUT_W-1:0] o_acc
);

  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_x;
  logic [OUT_W-1:0] w_inc;
  logic [OUT_W-1:0] w_sum;

  assign w_x   = OUT_W'(i_x);
  // Decoy steps add one extra only when corruption is enabled.
  assign w_inc = ((CORRUPT != 0) && i_decoy) ? OUT_W'(1) : '0;
  assign w_sum = r_acc + w_x + w_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else begin
      case (i_op)
        ACC_LOAD:  r_acc <= w_x;
        ACC_ADD:   r_acc <= w_sum;
        ACC_CLEAR: r_acc <= '0;
        default:   r_acc <= r_acc;
      endcase
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/keyed_dup_seq_ctrl.sv
// Key-locked multi-step accumulate sequencer with real/decoy step copies.
// Ports: clk, rst (async active-high), start, x (operand), key (live key
// bits), ack (result accepted), y (accumulator), busy (in a step), done.
module keyed_dup_seq_ctrl
  import keyed_fsm_pkg::*;
#(
  parameter int unsigned     KEY_W   = 4,
  parameter logic [KEY_W-1:0] KEY_VAL = KEY_W'(4'b1010),
  parameter int unsigned     IN_W    = 4,
  parameter int unsigned     OUT_W   = 8,
  parameter int unsigned     CORRUPT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  x,
  input  logic [KEY_W-1:0] key,
  input  logic             ack,
  output logic [OUT_W-1:0] y,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_W - 1);

  state_t           r_state;
  state_t           w_next;
  acc_op_e          w_op;
  logic             r_busy;
  logic             r_done;
  logic [IDX_W-1:0] w_nidx;
  logic [KEY_W-1:0] w_key_sh;
  logic [KEY_W-1:0] w_kv_sh;
  logic             w_canon;

  // Key and reference bit for the step about to be entered.
  assign w_nidx   = r_state.idx + IDX_W'(1);
  assign w_key_sh = key >> w_nidx;
  assign w_kv_sh  = KEY_VAL >> w_nidx;
  // IDLE and DONE are only legal with a zero index and no decoy flag.
  assign w_canon  = (r_state.idx == '0) && !r_state.decoy;

  // State register plus registered status decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next.phase == PH_STEP);
      r_done  <= (w_next.phase == PH_DONE);
    end
  end

  // Next-state and accumulator control.
  always_comb begin
    w_next = r_state;
    w_op   = ACC_HOLD;
    case (r_state.phase)
      PH_IDLE: begin
        if (!w_canon) begin
          w_next = ST_IDLE;
          w_op   = ACC_CLEAR;
        end else if (start) begin
          w_op   = ACC_LOAD;
          w_next = '{phase: PH_STEP, idx: '0, decoy: key_route(key[0], KEY_VAL[0])};
        end
      end
      PH_STEP: begin
        if (r_state.idx > LAST_IDX) begin
          w_next = ST_IDLE;
          w_op   = ACC_CLEAR;
        end else begin
          w_op = ACC_ADD;
          if (r_state.idx == LAST_IDX) begin
            w_next = ST_DONE;
          end else begin
            w_next = '{phase: PH_STEP, idx: w_nidx,
                       decoy: key_route(w_key_sh[0], w_kv_sh[0])};
          end
        end
      end
      PH_DONE: begin
        if (!w_canon) begin
          w_next = ST_IDLE;
          w_op   = ACC_CLEAR;
        end else if (ack) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
        w_op   = ACC_CLEAR;
      end
    endcase
  end

  keyed_step_acc #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .CORRUPT (CORRUPT)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_op    (w_op),
    .i_x     (x),
    .i_decoy (r_state.decoy),
    .o_acc   (y)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_keyed_dup_seq_ctrl.sv
// Scoreboard bench for keyed_dup_seq_ctrl: three instances share stimulus
// (default, CORRUPT=0, OUT_W=4) and results are checked against a model.
module tb_keyed_dup_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] x;
  logic [3:0] key;
  logic       ack;
  logic [7:0] ya;
  logic [7:0] yb;
  logic [3:0] yc;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int total = 0;
  int bad   = 0;
  int unsigned qa[$];
  int unsigned qb[$];
  int unsigned qc[$];
  int unsigned la, lb, lc;

  always #5 clk = ~clk;

  keyed_dup_seq_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start), .x(x), .key(key), .ack(ack),
    .y(ya), .busy(busy_a), .done(done_a));

  keyed_dup_seq_ctrl #(.CORRUPT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .x(x), .key(key), .ack(ack),
    .y(yb), .busy(busy_b), .done(done_b));

  keyed_dup_seq_ctrl #(.OUT_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start), .x(x), .key(key), .ack(ack),
    .y(yc), .busy(busy_c), .done(done_c));

  // ks[4*e +: 4] is the key present at edge e+1 (edge 1 = start edge).
  function automatic int unsigned model(input logic [3:0] c, input logic [15:0] ks,
                                        input int unsigned corrupt, input int unsigned outw);
    logic [3:0]  kv;
    int unsigned acc;
    kv  = 4'b1010;
    acc = int'(c);
    for (int k = 0; k < 4; k++) begin
      acc = acc + int'(c) + ((ks[5*k] != kv[k]) ? corrupt : 0);
    end
    return acc % (32'd1 << outw);
  endfunction

  function automatic logic [5:0] status();
    return {busy_a, busy_b, busy_c, done_a, done_b, done_c};
  endfunction

  task automatic do_run(input logic [3:0] c, input logic [15:0] ks,
                        input logic hold_start, input string nm);
    int waited;
    int unsigned ea, eb, ec;
    qa.push_back(model(c, ks, 1, 8));
    qb.push_back(model(c, ks, 0, 8));
    qc.push_back(model(c, ks, 1, 4));
    @(negedge clk);
    start = 1'b1;
    x     = c;
    key   = ks[3:0];
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (e <= 3) key = ks[4*e +: 4];
      total++;
      if (status() !== 6'b111000) begin
        bad++;
        $display("FAIL %s busy_after_edge%0d: got %b want 111000", nm, e, status());
      end
    end
    @(negedge clk);
    waited = 0;
    while (done_a !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited != 0) begin
      bad++;
      $display("FAIL %s latency: got %0d extra cycles want 0", nm, waited);
    end
    total++;
    if (status() !== 6'b000111) begin
      bad++;
      $display("FAIL %s done_status: got %b want 000111", nm, status());
    end
    ea = qa.pop_front();
    eb = qb.pop_front();
    ec = qc.pop_front();
    total++;
    if (ya !== 8'(ea)) begin bad++; $display("FAIL %s y_a: got %0d want %0d", nm, ya, ea); end
    total++;
    if (yb !== 8'(eb)) begin bad++; $display("FAIL %s y_b: got %0d want %0d", nm, yb, eb); end
    total++;
    if (yc !== 4'(ec)) begin bad++; $display("FAIL %s y_c: got %0d want %0d", nm, yc, ec); end
    la = ea;
    lb = eb;
    lc = ec;
  endtask

  task automatic check_idle_hold(input string nm);
    total++;
    if (status() !== 6'b000000) begin
      bad++;
      $display("FAIL %s idle_status: got %b want 000000", nm, status());
    end
    total++;
    if ({ya, yb, yc} !== {8'(la), 8'(lb), 4'(lc)}) begin
      bad++;
      $display("FAIL %s y_retained: got %0d/%0d/%0d want %0d/%0d/%0d", nm, ya, yb, yc, la, lb, lc);
    end
  endtask

  task automatic do_ack(input string nm);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check_idle_hold(nm);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x = '0; key = 4'b1010; ack = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ya, yb, yc, status()} !== 26'd0) begin
      bad++;
      $display("FAIL reset: got y=%0d/%0d/%0d st=%b want all zero", ya, yb, yc, status());
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ya, status()} !== 14'd0) begin
      bad++;
      $display("FAIL idle_after_reset: got y=%0d st=%b want zero", ya, status());
    end
  endtask

  task automatic test_correct_key();
    do_run(4'd3, {4{4'b1010}}, 1'b0, "correct");
    do_ack("correct_ack");
  endtask

  task automatic test_wrong_key();
    do_run(4'd3, {4{4'b0101}}, 1'b0, "all_wrong");
    do_ack("all_wrong_ack");
  endtask

  task automatic test_key_flip();
    do_run(4'd3, {4'b1110, 4'b1110, 4'b1010, 4'b1010}, 1'b0, "key_flip");
    do_ack("key_flip_ack");
  endtask

  task automatic test_wrap();
    do_run(4'd15, {4{4'b1010}}, 1'b0, "wrap");
    do_ack("wrap_ack");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; x = 4'd3; key = 4'b1010;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({ya, yb, yc, status()} !== 26'd0) begin
      bad++;
      $display("FAIL reset_mid: got y=%0d/%0d/%0d st=%b want all zero", ya, yb, yc, status());
    end
    @(negedge clk);
    rst = 1'b0;
    do_run(4'd1, {4{4'b1010}}, 1'b0, "after_reset");
    do_ack("after_reset_ack");
  endtask

  task automatic test_handshake();
    do_run(4'd2, {4{4'b1010}}, 1'b1, "start_held");
    @(negedge clk);
    total++;
    if (status() !== 6'b000111) begin
      bad++;
      $display("FAIL start_in_done: got %b want 000111", status());
    end
    ack = 1'b1;
    @(negedge clk);
    check_idle_hold("start_and_ack");
    start = 1'b0;
    ack   = 1'b0;
    @(negedge clk);
    check_idle_hold("no_restart");
    do_run(4'd4, {4'b0000, 4'b1111, 4'b0101, 4'b1010}, 1'b0, "mixed");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (status() !== 6'b000111 || ya !== 8'(la)) begin
        bad++;
        $display("FAIL ack_low_hold%0d: got st=%b y=%0d want 000111 y=%0d", i, status(), ya, la);
      end
    end
    do_ack("late_ack");
  endtask

  initial begin
    test_reset();
    test_correct_key();
    test_wrong_key();
    test_key_flip();
    test_wrap();
    test_reset_mid();
    test_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
